// File: rtl/ita_input_streamer_pkg.sv
// Shared types for the ITA input streamer: geometry, stream beat, write port and FSM states.
package ita_input_streamer_pkg;

    localparam int unsigned N  = 16;  // bytes per input stream beat
    localparam int unsigned E  = 64;  // embedding bytes per row
    localparam int unsigned S  = 64;  // maximum sequence length
    localparam int unsigned WI = 8;   // bits per activation byte

    localparam int unsigned InputAddrWidth  = $clog2(S);
    localparam int unsigned StreamBeatBytes = N;

    typedef logic [StreamBeatBytes*WI-1:0] stream_data_t;
    typedef logic [$clog2(S+1)-1:0]        seq_length_t;
    typedef logic [$clog2(E+1)-1:0]        embed_size_t;
    typedef logic [E*WI-1:0]               row_data_t;
    typedef logic [InputAddrWidth-1:0]     input_addr_t;

    typedef struct packed {
        input_addr_t addr;
        row_data_t   data;
    } write_port_t;

    typedef enum logic [1:0] {SIdle, SFill, SDrain, SFin} streamer_state_e;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/ita_input_streamer_if.sv
// Byte-stream input and row write-port output of the streamer; slave = streamer, master = host/sink.
interface ita_input_streamer_if #(
    parameter int unsigned BeatBytes = ita_input_streamer_pkg::StreamBeatBytes
);
    import ita_input_streamer_pkg::*;

    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [BeatBytes*WI-1:0]   in_data_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    write_port_t               out_port_o;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_port_o
    );

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_port_o
    );

endinterface

// File: rtl/ita_row_assembler.sv
// Collects BeatBytes-wide beats into one E-byte row; bytes at or beyond embed_size read as zero.
module ita_row_assembler
    import ita_input_streamer_pkg::*;
#(
    parameter  int unsigned BeatBytes    = StreamBeatBytes,
    localparam int unsigned RowBeats     = E / BeatBytes,
    localparam int unsigned BeatCntWidth = (RowBeats > 1) ? $clog2(RowBeats) : 1,
    localparam int unsigned BprWidth     = $clog2(RowBeats + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    beat_valid_i,
    input  logic [BeatBytes*WI-1:0] beat_data_i,
    input  embed_size_t             embed_size_i,
    input  logic [BprWidth-1:0]     bpr_i,
    output logic                    last_beat_o,
    output row_data_t               row_o
);

    localparam int unsigned BeatWidth = BeatBytes * WI;

    logic [BeatCntWidth-1:0] beat_cnt_q;
    row_data_t               row_q;

    assign last_beat_o = (BprWidth'(beat_cnt_q) + BprWidth'(1)) == bpr_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            beat_cnt_q <= '0;
            // NOTE: the row buffer is cleared on reset so no bytes of an aborted row can leak into the next transfer.
            row_q      <= '0;
        end else if (clear_i) begin
            beat_cnt_q <= '0;
        end else if (beat_valid_i) begin
            // NOTE: non-blocking assignments keep every register update tied to the edge, independent of statement order.
            for (int b = 0; b < int'(RowBeats); b++) begin
                if (beat_cnt_q == BeatCntWidth'(b)) row_q[b*BeatWidth +: BeatWidth] <= beat_data_i;
            end
            beat_cnt_q <= last_beat_o ? '0 : beat_cnt_q + BeatCntWidth'(1);
        end
    end

    // The beat arriving this cycle is overlaid so the final beat completes the row without a bubble.
    always_comb begin
        // NOTE: row_o is given a full default before any conditional write, so no latch can be inferred.
        row_o = row_q;
        for (int b = 0; b < int'(RowBeats); b++) begin
            if (beat_valid_i && beat_cnt_q == BeatCntWidth'(b)) row_o[b*BeatWidth +: BeatWidth] = beat_data_i;
        end
        for (int i = 0; i < int'(E); i++) begin
            if (i >= int'(embed_size_i)) row_o[i*WI +: WI] = '0;
        end
    end

endmodule

// File: rtl/ita_input_streamer.sv
// Streams activation beats into E-byte rows and writes them to the ITA input buffer, one row per address.
// Optional in_last_i framing check with sticky err_o when ITA_INPUT_STREAMER_LAST_CHECK_EN is defined.
module ita_input_streamer
    import ita_input_streamer_pkg::*;
#(
    parameter int unsigned BeatBytes = N
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  seq_length_t           seq_length_i,
    input  embed_size_t           embed_size_i,
`ifdef ITA_INPUT_STREAMER_LAST_CHECK_EN
    input  logic                  in_last_i,
    output logic                  err_o,
`endif
    output logic                  busy_o,
    output logic                  done_o,
    ita_input_streamer_if.slave   bus
);

    localparam int unsigned RowBeats = E / BeatBytes;
    localparam int unsigned BprWidth = $clog2(RowBeats + 1);

    if (E % BeatBytes != 0) begin : g_bad_beat_bytes
        $error("BeatBytes must divide E");
    end

    streamer_state_e     state_q, state_d;
    seq_length_t         seq_len_q;
    embed_size_t         embed_q;
    logic [BprWidth-1:0] bpr_q;
    seq_length_t         row_cnt_q;
    logic                out_valid_q;
    write_port_t         out_port_q;

    logic      in_ready, in_fire, out_fire, start_ok;
    logic      last_beat, row_done, last_row;
    row_data_t row;

    // Stall only the row-completing beat, and only when the output register cannot drain this cycle.
    assign in_ready = (state_q == SFill) && !(last_beat && out_valid_q && !bus.out_ready_i);
    assign in_fire  = bus.in_valid_i && in_ready;
    assign out_fire = out_valid_q && bus.out_ready_i;
    assign start_ok = start_i && (state_q == SIdle);
    assign row_done = in_fire && last_beat;
    assign last_row = row_cnt_q == seq_len_q - seq_length_t'(1);
    assign busy_o   = (state_q == SFill) || (state_q == SDrain);

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_port_o  = out_port_q;

    ita_row_assembler #(.BeatBytes(BeatBytes)) u_row_assembler (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (start_ok),
        .beat_valid_i (in_fire),
        .beat_data_i  (bus.in_data_i),
        .embed_size_i (embed_q),
        .bpr_i        (bpr_q),
        .last_beat_o  (last_beat),
        .row_o        (row)
    );

    always_comb begin
        state_d = state_q;
        done_o  = 1'b0;
        unique case (state_q)
            SIdle:   if (start_i) state_d = (seq_length_i == '0 || embed_size_i == '0) ? SFin : SFill;
            SFill:   if (row_done && last_row) state_d = SDrain;
            SDrain:  if (out_fire) state_d = SFin;
            SFin: begin
                done_o  = 1'b1;
                state_d = SIdle;
            end
            default: state_d = SIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= SIdle;
            seq_len_q   <= '0;
            embed_q     <= '0;
            bpr_q       <= '0;
            row_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_port_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                seq_len_q <= seq_length_i;
                embed_q   <= embed_size_i;
                bpr_q     <= BprWidth'(ceil_div(32'(embed_size_i), BeatBytes));
                row_cnt_q <= '0;
            end
            // A completed row may overwrite the register in the same cycle its predecessor is accepted.
            if (row_done) begin
                out_port_q.addr <= row_cnt_q[InputAddrWidth-1:0];
                out_port_q.data <= row;
                out_valid_q     <= 1'b1;
                row_cnt_q       <= row_cnt_q + seq_length_t'(1);
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef ITA_INPUT_STREAMER_LAST_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (in_fire && (in_last_i != (last_beat && last_row))) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

endmodule
